// File: rtl/score_seg_display_if.sv
// Score load handshake between the game core (master) and the score display (slave).
interface score_seg_display_if #(
  parameter int unsigned SCORE_W = 11
);
  logic [SCORE_W-1:0] score_in;
  logic               score_valid;
  logic               busy;

  modport master (output score_in, output score_valid, input busy);
  modport slave  (input score_in, input score_valid, output busy);
endinterface

// File: rtl/score_seg_display.sv
// Binary score -> 4 BCD digits (sequential double dabble), multiplexed onto a 4-digit
// active-low seven-segment display. Define SEG_BLANK_EN for leading-zero blanking.
module score_seg_display #(
  parameter int unsigned SCORE_W     = 11,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned MAX_SHOWN   = 9999
) (
  input  logic               clk,
  input  logic               reset,
  score_seg_display_if.slave bus,
  output logic [3:0]         an,
  output logic [6:0]         seg
);
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(SCORE_W + 1);
  localparam int unsigned DD_W  = 16 + SCORE_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state, state_next;
  logic [SCORE_W-1:0] pend_val;
  logic               pending;
  logic [SCORE_W-1:0] operand;
  logic [15:0]        bcd;
  logic [15:0]        disp;
  logic [BIT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   refresh_cnt;
  logic [1:0]         digit_idx;

  logic [SCORE_W-1:0] sat_c;
  logic [15:0]        adj_c;
  logic [DD_W-1:0]    dd_c;
  logic [1:0]         next_idx_c;
  logic [3:0]         nib_c;
  logic               blank_c;
  logic [3:0]         an_c;
  logic [6:0]         seg_c;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b0000001;
      4'd1:    seg_of = 7'b1001111;
      4'd2:    seg_of = 7'b0010010;
      4'd3:    seg_of = 7'b0000110;
      4'd4:    seg_of = 7'b1001100;
      4'd5:    seg_of = 7'b0100100;
      4'd6:    seg_of = 7'b0100000;
      4'd7:    seg_of = 7'b0001111;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0001100;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.score_valid || pending) state_next = S_LOAD;
      S_LOAD:  state_next = S_SHIFT;
      S_SHIFT: if (bit_cnt == BIT_W'(1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Saturation and one double-dabble step (adjust nibbles, then shift the whole register)
  always_comb begin
    sat_c = pend_val;
    if (32'(pend_val) > MAX_SHOWN) sat_c = SCORE_W'(MAX_SHOWN);
    adj_c = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    dd_c = {adj_c, operand} << 1;
  end

  // Input capture, conversion datapath, display register; latest score_valid always wins
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_val <= '0;
      pending  <= 1'b0;
      operand  <= '0;
      bcd      <= '0;
      disp     <= '0;
      bit_cnt  <= '0;
      bus.busy <= 1'b0;
    end else begin
      bus.busy <= (state_next != S_IDLE);
      if (bus.score_valid) pend_val <= bus.score_in;
      if (state == S_IDLE)        pending <= 1'b0;
      else if (bus.score_valid)   pending <= 1'b1;
      case (state)
        S_LOAD: begin
          operand <= sat_c;
          bcd     <= '0;
          bit_cnt <= BIT_W'(SCORE_W);
        end
        S_SHIFT: begin
          bcd     <= dd_c[SCORE_W +: 16];
          operand <= dd_c[SCORE_W-1:0];
          bit_cnt <= bit_cnt - BIT_W'(1);
        end
        S_DONE:  disp <= bcd;
        default: ;
      endcase
    end
  end

  // Pattern for the slot about to start
  always_comb begin
    next_idx_c = digit_idx + 2'd1;
    nib_c      = disp[{next_idx_c, 2'b00} +: 4];
`ifdef SEG_BLANK_EN
    case (next_idx_c)
      2'd1:    blank_c = (disp[15:4]  == 12'd0);
      2'd2:    blank_c = (disp[15:8]  == 8'd0);
      2'd3:    blank_c = (disp[15:12] == 4'd0);
      default: blank_c = 1'b0;
    endcase
`else
    blank_c = 1'b0;
`endif
    an_c  = blank_c ? 4'b1111 : ~(4'b0001 << next_idx_c);
    seg_c = blank_c ? 7'b1111111 : seg_of(nib_c);
  end

  // Digit scan: an/seg only change at slot boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      an          <= 4'b1110;
      seg         <= 7'b0000001;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= next_idx_c;
      an          <= an_c;
      seg         <= seg_c;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end
endmodule
